wbm_byte_bridge: RTL and testbench

//  Parametrised Wishbone B4 pipelined master driven by a full-duplex byte stream

---
 rtl/wbm_byte_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_wbm_byte_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_byte_bridge.sv
// ---------------------------------------------------------------------------
// wbm_byte_bridge
//
// Wishbone B4 pipelined master driven by a full-duplex byte stream that is
// already synchronised into wb_clk_i. Every received byte produces exactly
// one transmit byte one cycle later. That byte is returned on the next
// exchange.
//
// Frame: command byte {WE, N-1, SEL}, then ADDR_BYTES word-address bytes
// (MSB first). A write continues with DATA_BYTES data bytes per word. Every
// Wishbone cycle is followed by status polling: FF means still busy, 00 means
// ack, EE means error. A read word is returned MSB first after its 00 status.
// Bursts auto-increment the word address, wrapping within the address field.
//
// Optional feature: define WBM_BYTE_BRIDGE_TIMEOUT_EN to abandon a Wishbone
// cycle that sees no ack/err within TIMEOUT_CYCLES clocks. That cycle is
// reported as an error. Without the macro the bridge waits indefinitely.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_cyc_o .. wb_dat_o        Wishbone master outputs (registered)
//   wb_dat_i, wb_stall_i,
//   wb_ack_i, wb_err_i          Wishbone slave responses
//   rx_stb_i, rx_data_i         one received byte per pulse
//   abort_i                     frame end; cancels any transaction
//   tx_stb_o, tx_data_o         byte for the next exchange (pulse + data)
//   busy_o                      high while a frame is in progress
// ---------------------------------------------------------------------------
module wbm_byte_bridge #(
  parameter int  ADDR_BYTES     = 1,
  parameter int  DATA_BYTES     = 4,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int ADR_W          = 8*ADDR_BYTES + $clog2(DATA_BYTES)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_BYTES-1:0]   wb_sel_o,
  output logic [ADR_W-1:0]        wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  input  logic                    wb_stall_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    rx_stb_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    abort_i,
  output logic                    tx_stb_o,
  output logic [7:0]              tx_data_o,
  output logic                    busy_o
);

  localparam int LSB_W = $clog2(DATA_BYTES);
  localparam int WA_W  = 8*ADDR_BYTES;
  localparam int DAT_W = 8*DATA_BYTES;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

`ifdef WBM_BYTE_BRIDGE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  state_t           state;
  logic [WA_W-1:0]  word_adr;    // word address; byte lanes appended below
  logic [DAT_W-1:0] rd_word;     // read data, shifted out MSB first
  logic [2:0]       burst_left;  // words still to transfer after the current one
  logic [1:0]       byte_cnt;    // byte index inside the address or data field
  logic             err_seen;    // last Wishbone cycle ended in error/timeout
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit;

  // Counter is constant zero when the timeout feature is compiled out.
  assign timeout_hit = TIMEOUT_EN && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  if (LSB_W == 0) begin : g_adr_word
    assign wb_adr_o = word_adr;
  end else begin : g_adr_byte
    assign wb_adr_o = {word_adr, {LSB_W{1'b0}}};
  end

  assign busy_o = (state != ST_CMD);

  // NOTE: every register here is assigned with <= so all state updates read
  // the pre-edge values; mixing in = would make the result order dependent.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_CMD;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      word_adr   <= '0;
      rd_word    <= '0;
      burst_left <= '0;
      byte_cnt   <= '0;
      err_seen   <= 1'b0;
      to_cnt     <= '0;
      tx_stb_o   <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      tx_stb_o <= rx_stb_i;

      // Cycle-age counter: zero while idle, counts every cycle cyc is high.
      if (TIMEOUT_EN && wb_cyc_o) to_cnt <= to_cnt + 1'b1;
      else                        to_cnt <= '0;

      if (abort_i) begin
        wb_cyc_o   <= 1'b0;
        wb_stb_o   <= 1'b0;
        state      <= ST_CMD;
        tx_data_o  <= 8'h00;
        burst_left <= '0;
        byte_cnt   <= '0;
      end else begin
        // ---------------- Wishbone side ----------------
        if (wb_stb_o && !wb_stall_i) wb_stb_o <= 1'b0;

        if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          err_seen <= wb_err_i;
          if (wb_ack_i) rd_word <= wb_dat_i;
        end else if (wb_cyc_o && timeout_hit) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          err_seen <= 1'b1;
        end

        // ---------------- byte side ----------------
        // Status decisions use the registered cyc: an ack arriving on the
        // same edge as a byte still answers FF, status follows next byte.
        if (rx_stb_i) begin
          unique case (state)
            ST_CMD: begin
              tx_data_o  <= 8'hFF;
              wb_we_o    <= rx_data_i[7];
              burst_left <= rx_data_i[6:4];
              wb_sel_o   <= rx_data_i[DATA_BYTES-1:0];
              byte_cnt   <= '0;
              state      <= ST_ADDR;
            end

            ST_ADDR: begin
              tx_data_o <= 8'hFF;
              word_adr  <= WA_W'({word_adr, rx_data_i});
              if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                byte_cnt <= '0;
                if (wb_we_o) begin
                  state <= ST_WR_DATA;
                end else begin
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  err_seen <= 1'b0;
                  state    <= ST_RD_WAIT;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end

            ST_WR_DATA: begin
              tx_data_o <= 8'hFF;
              wb_dat_o  <= DAT_W'({wb_dat_o, rx_data_i});
              if (byte_cnt == 2'(DATA_BYTES - 1)) begin
                byte_cnt <= '0;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                err_seen <= 1'b0;
                state    <= ST_WR_WAIT;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end

            ST_WR_WAIT: begin
              if (wb_cyc_o) begin
                tx_data_o <= 8'hFF;
              end else if (err_seen) begin
                tx_data_o  <= 8'hEE;
                burst_left <= '0;
                state      <= ST_CMD;
              end else begin
                tx_data_o <= 8'h00;
                if (burst_left != '0) begin
                  burst_left <= burst_left - 1'b1;
                  word_adr   <= word_adr + 1'b1;
                  state      <= ST_WR_DATA;
                end else begin
                  state <= ST_CMD;
                end
              end
            end

            ST_RD_WAIT: begin
              if (wb_cyc_o) begin
                tx_data_o <= 8'hFF;
              end else if (err_seen) begin
                tx_data_o  <= 8'hEE;
                burst_left <= '0;
                state      <= ST_CMD;
              end else begin
                tx_data_o <= 8'h00;
                byte_cnt  <= '0;
                state     <= ST_RD_DATA;
              end
            end

            ST_RD_DATA: begin
              tx_data_o <= rd_word[DAT_W-1 -: 8];
              rd_word   <= rd_word << 8;
              if (byte_cnt == 2'(DATA_BYTES - 1)) begin
                byte_cnt <= '0;
                if (burst_left != '0) begin
                  burst_left <= burst_left - 1'b1;
                  word_adr   <= word_adr + 1'b1;
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  err_seen   <= 1'b0;
                  state      <= ST_RD_WAIT;
                end else begin
                  state <= ST_CMD;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end

            default: state <= ST_CMD;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wbm_byte_bridge.sv
// ---------------------------------------------------------------------------
// tb_wbm_byte_bridge
//
// Self-checking bench for wbm_byte_bridge (ADDR_BYTES=1, DATA_BYTES=4,
// TIMEOUT_CYCLES=16). A behavioural Wishbone slave has a configurable stall
// count, ack latency and error word, and logs every accepted request.
// Frames come from a vector table and from $urandom. They are compared
// against a transaction-level expectation: the bus requests and the status
// and data bytes the host must see. Hand-written sequences cover reset,
// ack/byte on the same edge, abort, and the no-ack / timeout behaviour.
// ---------------------------------------------------------------------------
module tb_wbm_byte_bridge;

  localparam int ADDR_BYTES     = 1;
  localparam int DATA_BYTES     = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int ADR_W          = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]        wb_sel_o;
  logic [ADR_W-1:0]  wb_adr_o;
  logic [31:0]       wb_dat_o, wb_dat_i;
  logic              wb_stall_i, wb_ack_i, wb_err_i;
  logic              rx_stb_i, abort_i;
  logic [7:0]        rx_data_i;
  logic              tx_stb_o, busy_o;
  logic [7:0]        tx_data_o;

  always #5 clk = ~clk;

  wbm_byte_bridge #(
    .ADDR_BYTES    (ADDR_BYTES),
    .DATA_BYTES    (DATA_BYTES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_stall_i(wb_stall_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .rx_stb_i  (rx_stb_i),
    .rx_data_i (rx_data_i),
    .abort_i   (abort_i),
    .tx_stb_o  (tx_stb_o),
    .tx_data_o (tx_data_o),
    .busy_o    (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  typedef struct {
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  logic [31:0] mem [256];
  txn_t        log_q[$];
  txn_t        acc;
  int          cfg_stall, cfg_lat, cfg_err_idx;
  int          txn_cnt, stall_left, lat_left, p_idx;
  bit          pend;
  logic [7:0]  p_adr;
  int          stb_hi, cyc_hi;

  // Slave reacts on the falling edge so its responses are stable at the
  // next rising edge; cfg_lat = 0 means never answer.
  initial begin
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    pend = 1'b0; stall_left = 0; lat_left = 0; p_idx = 0; p_adr = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (!wb_cyc_o) begin
        pend       = 1'b0;
        stall_left = cfg_stall;
        wb_stall_i = 1'b0;
      end else begin
        if (pend) begin
          lat_left--;
          if (cfg_lat != 0 && lat_left == 0) begin
            pend = 1'b0;
            if (p_idx == cfg_err_idx) wb_err_i = 1'b1;
            else begin
              wb_ack_i = 1'b1;
              wb_dat_i = mem[p_adr];
            end
          end
        end
        if (wb_stb_o && stall_left > 0) begin
          wb_stall_i = 1'b1;
          stall_left--;
        end else begin
          wb_stall_i = 1'b0;
          if (wb_stb_o) begin
            acc.we  = wb_we_o;
            acc.adr = wb_adr_o;
            acc.sel = wb_sel_o;
            acc.dat = wb_dat_o;
            log_q.push_back(acc);
            pend     = 1'b1;
            lat_left = cfg_lat;
            p_idx    = txn_cnt;
            p_adr    = wb_adr_o[9:2];
            txn_cnt++;
          end
        end
      end
    end
  end

  initial begin
    stb_hi = 0;
    cyc_hi = 0;
    forever begin
      @(negedge clk);
      if (wb_stb_o) stb_hi++;
      if (wb_cyc_o) cyc_hi++;
    end
  end

  // ---------------- byte host ----------------
  // NOTE: inputs are driven with blocking assignments 1 time unit after the
  // falling edge, and outputs are sampled on the falling edge, so nothing
  // races the DUT's rising edge.
  task automatic xfer(input logic [7:0] b, output logic [7:0] resp);
    rx_stb_i  = 1'b1;
    rx_data_i = b;
    @(negedge clk);
    resp = tx_data_o;
    check("tx_stb_pulse", 32'(tx_stb_o), 32'd1);
    #1;
    rx_stb_i  = 1'b0;
    rx_data_i = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] resp);
    @(negedge clk);
    check("tx_stb_idle", 32'(tx_stb_o), 32'd0);
    #1;
    xfer(b, resp);
  endtask

  // Dummy bytes until a non-FF status byte; FF after the bound fails the caller's check.
  task automatic poll_status(output logic [7:0] st);
    st = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      send_byte(8'($urandom), st);
      if (st != 8'hFF) break;
    end
  endtask

  task automatic reset_counters();
    @(negedge clk);
    #1;
    txn_cnt = 0;
    log_q.delete();
    stb_hi = 0;
    cyc_hi = 0;
  endtask

  // ---------------- frame-level reference ----------------
  typedef struct {
    bit          we;
    int          n;
    logic [3:0]  sel;
    logic [7:0]  addr;
    int          err_idx;   // word that gets wb_err_i; >= n means none
    int          stall;
    int          lat;
    logic [31:0] d0;
  } vec_t;

  task automatic run_frame(input vec_t v);
    logic [31:0] wdata [8];
    txn_t        exp_q[$];
    txn_t        e;
    logic [7:0]  r;
    logic [7:0]  exp_st;
    logic [31:0] word;
    int          issued;

    reset_counters();
    cfg_stall   = v.stall;
    cfg_lat     = v.lat;
    cfg_err_idx = v.err_idx;

    for (int i = 0; i < 8; i++) wdata[i] = (i == 0) ? v.d0 : $urandom;
    issued = (v.err_idx < v.n) ? v.err_idx + 1 : v.n;
    for (int i = 0; i < issued; i++) begin
      e.we  = v.we;
      e.adr = {8'(int'(v.addr) + i), 2'b00};
      e.sel = v.sel;
      e.dat = v.we ? wdata[i] : 32'h0;
      exp_q.push_back(e);
    end

    send_byte({v.we, 3'(v.n - 1), v.sel}, r);
    check("cmd_resp", 32'(r), 32'hFF);
    send_byte(v.addr, r);
    check("addr_resp", 32'(r), 32'hFF);

    for (int i = 0; i < v.n; i++) begin
      if (v.we) begin
        for (int b = 0; b < 4; b++) begin
          send_byte(wdata[i][31-8*b -: 8], r);
          check("wr_byte_resp", 32'(r), 32'hFF);
        end
      end
      exp_st = (i == v.err_idx) ? 8'hEE : 8'h00;
      poll_status(r);
      check("status", 32'(r), 32'(exp_st));
      if (r != exp_st || exp_st == 8'hEE) break;
      if (!v.we) begin
        word = mem[8'(int'(v.addr) + i)];
        for (int b = 0; b < 4; b++) begin
          send_byte(8'($urandom), r);
          check("rd_byte", 32'(r), 32'(word[31-8*b -: 8]));
        end
      end
    end

    @(negedge clk);
    check("busy_end", 32'(busy_o), 32'd0);
    check("cyc_end", 32'(wb_cyc_o), 32'd0);
    check("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("txn_we",  32'(log_q[i].we),  32'(exp_q[i].we));
      check("txn_adr", 32'(log_q[i].adr), 32'(exp_q[i].adr));
      check("txn_sel", 32'(log_q[i].sel), 32'(exp_q[i].sel));
      if (v.we) check("txn_dat", log_q[i].dat, exp_q[i].dat);
    end
    check("stb_cycles", 32'(stb_hi), 32'(issued * (v.stall + 1)));
  endtask

  // ---------------- main sequence ----------------
  vec_t       vecs [8];
  vec_t       rv;
  logic [7:0] r;
  bit         seen;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"},     32'(wb_cyc_o),  32'd0);
    check({tag, "_stb"},     32'(wb_stb_o),  32'd0);
    check({tag, "_we"},      32'(wb_we_o),   32'd0);
    check({tag, "_sel"},     32'(wb_sel_o),  32'd0);
    check({tag, "_adr"},     32'(wb_adr_o),  32'd0);
    check({tag, "_dat"},     wb_dat_o,       32'd0);
    check({tag, "_tx_stb"},  32'(tx_stb_o),  32'd0);
    check({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
    check({tag, "_busy"},    32'(busy_o),    32'd0);
  endtask

  initial begin
    //          we    n  sel    addr   err stall lat d0
    vecs[0] = '{1'b0, 1, 4'hF, 8'h05, 99, 0, 3, 32'h0};          // single read
    vecs[1] = '{1'b1, 1, 4'h3, 8'h10, 99, 0, 1, 32'h11223344};   // single write
    vecs[2] = '{1'b0, 3, 4'hF, 8'hFF, 99, 0, 2, 32'h0};          // read burst, wrap
    vecs[3] = '{1'b1, 1, 4'hF, 8'h20, 99, 4, 2, 32'hCAFEF00D};   // stalled write
    vecs[4] = '{1'b1, 2, 4'hF, 8'h30, 0,  0, 1, 32'h55AA55AA};   // write err word 0
    vecs[5] = '{1'b0, 2, 4'h5, 8'h40, 1,  1, 2, 32'h0};          // read err word 1
    vecs[6] = '{1'b1, 8, 4'hA, 8'hFC, 99, 2, 1, 32'h01020304};   // max write burst, wrap
    vecs[7] = '{1'b0, 1, 4'h1, 8'h00, 99, 0, 1, 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h05] = 32'hDEADBEEF;
    cfg_stall = 0; cfg_lat = 1; cfg_err_idx = 99; txn_cnt = 0;
    rst = 1'b1; rx_stb_i = 1'b0; rx_data_i = '0; abort_i = 1'b0;

    // Reset, with a byte strobe held during it that must be ignored.
    repeat (2) @(negedge clk);
    rx_stb_i = 1'b1; rx_data_i = 8'h8F;
    @(negedge clk);
    rx_stb_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b0;

    // Table-driven frames.
    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      rv.we      = 1'($urandom);
      rv.n       = 1 + int'($urandom_range(0, 7));
      rv.sel     = 4'($urandom);
      rv.addr    = 8'($urandom);
      rv.err_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rv.n - 1)) : 99;
      rv.stall   = int'($urandom_range(0, 2));
      rv.lat     = int'($urandom_range(1, 4));
      rv.d0      = $urandom;
      run_frame(rv);
    end

    // Ack and a byte on the same edge: FF first, status on the next byte.
    reset_counters();
    cfg_stall = 0; cfg_lat = 4; cfg_err_idx = 99;
    send_byte(8'h0F, r);
    send_byte(8'h07, r);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = wb_ack_i;
    end
    check("ack_seen", 32'(seen), 32'd1);
    xfer(8'h00, r);
    check("ack_same_edge_ff", 32'(r), 32'hFF);
    send_byte(8'h00, r);
    check("ack_next_status", 32'(r), 32'h00);
    for (int b = 0; b < 4; b++) begin
      send_byte(8'h00, r);
      check("same_edge_rd_byte", 32'(r), 32'(mem[8'h07][31-8*b -: 8]));
    end

    // Slave that never answers.
    reset_counters();
    cfg_stall = 0; cfg_lat = 0; cfg_err_idx = 99;
    send_byte(8'h0F, r);
    send_byte(8'h0A, r);
`ifdef WBM_BYTE_BRIDGE_TIMEOUT_EN
    poll_status(r);
    check("timeout_status", 32'(r), 32'hEE);
    check("timeout_cyc_len", 32'(cyc_hi), 32'(TIMEOUT_CYCLES));
    @(negedge clk);
    check("timeout_busy", 32'(busy_o), 32'd0);
`else
    repeat (40) @(negedge clk);
    check("noack_cyc_held", 32'(wb_cyc_o), 32'd1);
    send_byte(8'h00, r);
    check("noack_poll_ff", 32'(r), 32'hFF);
    check("noack_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    #1 abort_i = 1'b1;
    @(negedge clk);
    #1 abort_i = 1'b0;
`endif

    // Abort during RD_WAIT with stb held by stall; a byte on the same edge is ignored.
    reset_counters();
    cfg_stall = 100; cfg_lat = 0; cfg_err_idx = 99;
    send_byte(8'h0F, r);
    send_byte(8'h09, r);
    repeat (3) @(negedge clk);
    check("abort_pre_cyc", 32'(wb_cyc_o), 32'd1);
    check("abort_pre_stb", 32'(wb_stb_o), 32'd1);
    #1;
    abort_i   = 1'b1;
    rx_stb_i  = 1'b1;
    rx_data_i = 8'h8F;
    @(negedge clk);
    check("abort_cyc",  32'(wb_cyc_o),  32'd0);
    check("abort_stb",  32'(wb_stb_o),  32'd0);
    check("abort_busy", 32'(busy_o),    32'd0);
    check("abort_tx",   32'(tx_data_o), 32'h00);
    #1;
    abort_i  = 1'b0;
    rx_stb_i = 1'b0;
    run_frame(vecs[7]);

    // Reset in the middle of a write data phase.
    reset_counters();
    cfg_stall = 0; cfg_lat = 1; cfg_err_idx = 99;
    send_byte(8'h8F, r);
    send_byte(8'h33, r);
    send_byte(8'hAB, r);
    send_byte(8'hCD, r);
    check("wr_shift", 32'(wb_dat_o[15:0]), 32'hABCD);
    check("wr_busy", 32'(busy_o), 32'd1);
    #1;
    rst      = 1'b1;
    rx_stb_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    #1;
    rst      = 1'b0;
    rx_stb_i = 1'b0;
    run_frame(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
